// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline stage register with optional skid entry, stall/flush control and perf counters
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 32,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count,
  output logic [CNT_W-1:0]  bubble_count,
  output logic [1:0]        status
);
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic rdy_q, in_fire, out_fire;
  // handshake decode; with a skid entry in_ready depends only on held state and stall, never on out_ready
  always_comb begin
    in_ready = rdy_q && !stall && (SKID != 0 ? occupancy != 2'd2 : (occupancy == 2'd0 || out_ready));
    out_valid = occupancy != 2'd0 && !stall && !flush;
    in_fire = in_valid && in_ready && !flush;
    out_fire = out_valid && out_ready;
    out_data = main_data;
    out_ctrl = out_valid ? main_ctrl : '0;
  end
  // main holds the head and skid the newer entry; a head transfer promotes skid into main on the same edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
      occupancy <= 2'd0;
      rdy_q <= 1'b0;
    end else if (flush) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
      occupancy <= 2'd0;
      rdy_q <= 1'b1;
    end else begin
      occupancy <= occupancy + {1'b0, in_fire} - {1'b0, out_fire};
      rdy_q <= 1'b1;
      if (out_fire && occupancy == 2'd2) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end else if (in_fire && (occupancy == 2'd0 || out_fire)) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end
      if (in_fire && occupancy == 2'd1 && !out_fire) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  // saturating performance counters and registered status, flush > stall > backpressure > normal
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stall_count <= '0;
      flush_count <= '0;
      bubble_count <= '0;
      status <= 2'b00;
    end else begin
      stall_count <= stall_count + CNT_W'(stall && !(&stall_count));
      flush_count <= flush_count + CNT_W'(flush && !(&flush_count));
      bubble_count <= bubble_count + CNT_W'(occupancy == 2'd0 && out_ready && !stall && !(&bubble_count));
      status <= flush ? 2'b10 : stall ? 2'b01 : (out_valid && !out_ready) ? 2'b11 : 2'b00;
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: checks a skid (CNT_W=4) and a single-register (SKID=0) stage against a FIFO reference model
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int CW = 12;
  logic clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, stall = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic ir0, ov0, ir1, ov1;
  logic [DW-1:0] od0, od1;
  logic [CW-1:0] oc0, oc1;
  logic [1:0] occ0, occ1, st0, st1;
  logic [3:0] sc0, fc0, bc0;
  logic [15:0] sc1, fc1, bc1;
  int checks = 0, failures = 0;
  logic [CW+DW-1:0] fq [2][2];
  int fn [2], m_sc [2], m_fc [2], m_bc [2];
  logic [1:0] m_st [2];
  bit m_up [2];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4), .SKID(1)) u_skid (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data), .in_ctrl(in_ctrl),
    .stall(stall), .flush(flush), .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ctrl(oc0),
    .occupancy(occ0), .stall_count(sc0), .flush_count(fc0), .bubble_count(bc0), .status(st0));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16), .SKID(0)) u_reg (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data), .in_ctrl(in_ctrl),
    .stall(stall), .flush(flush), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ctrl(oc1),
    .occupancy(occ1), .stall_count(sc1), .flush_count(fc1), .bubble_count(bc1), .status(st1));

  function automatic int cmax(input int d);
    return d == 0 ? 15 : 65535;
  endfunction

  function automatic bit e_ir(input int d);
    return m_up[d] && !stall && (d == 0 ? fn[d] < 2 : (fn[d] == 0 || out_ready));
  endfunction

  function automatic bit e_ov(input int d);
    return fn[d] > 0 && !stall && !flush;
  endfunction

  task automatic chk(input string tag, input int d, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s dut%0d got=%0h exp=%0h", tag, d, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      fn[d] = 0;
      m_sc[d] = 0;
      m_fc[d] = 0;
      m_bc[d] = 0;
      m_st[d] = 2'd0;
      m_up[d] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [CW+DW-1:0] h;
      h = fn[d] > 0 ? fq[d][0] : '0;
      chk("in_ready", d, 64'(d == 1 ? ir1 : ir0), 64'(e_ir(d)));
      chk("out_valid", d, 64'(d == 1 ? ov1 : ov0), 64'(e_ov(d)));
      chk("out_ctrl", d, 64'(d == 1 ? oc1 : oc0), e_ov(d) ? 64'(h[CW+DW-1:DW]) : 64'd0);
      if (!m_up[d] || fn[d] > 0) chk("out_data", d, 64'(d == 1 ? od1 : od0), 64'(h[DW-1:0]));
      chk("occupancy", d, 64'(d == 1 ? occ1 : occ0), 64'(fn[d]));
      chk("stall_count", d, d == 1 ? 64'(sc1) : 64'(sc0), 64'(m_sc[d]));
      chk("flush_count", d, d == 1 ? 64'(fc1) : 64'(fc0), 64'(m_fc[d]));
      chk("bubble_count", d, d == 1 ? 64'(bc1) : 64'(bc0), 64'(m_bc[d]));
      chk("status", d, 64'(d == 1 ? st1 : st0), 64'(m_st[d]));
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit fi, fo;
      if (reset_n) begin
        fi = in_valid && e_ir(d) && !flush;
        fo = e_ov(d) && out_ready;
        if (stall && m_sc[d] < cmax(d)) m_sc[d]++;
        if (flush && m_fc[d] < cmax(d)) m_fc[d]++;
        if (fn[d] == 0 && out_ready && !stall && m_bc[d] < cmax(d)) m_bc[d]++;
        m_st[d] = flush ? 2'd2 : stall ? 2'd1 : (e_ov(d) && !out_ready) ? 2'd3 : 2'd0;
        if (flush) fn[d] = 0;
        else begin
          if (fo) begin
            fq[d][0] = fq[d][1];
            fn[d]--;
          end
          if (fi && fn[d] < 2) begin
            fq[d][fn[d]] = {in_ctrl, in_data};
            fn[d]++;
          end
        end
        m_up[d] = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("ready_after_reset", 0, 64'(ir0), 64'd1);
    in_valid = 1'b1; in_data = 32'h4; in_ctrl = 12'h5a5; out_ready = 1'b1;
    cyc();
    chk("latency_valid", 0, 64'(ov0), 64'd1);
    chk("latency_data", 0, 64'(od0), 64'h4);
    in_valid = 1'b0;
    cyc();
    chk("latency_drained", 0, 64'(ov0), 64'd0);
    cyc();
    cyc();
    chk("bubble_idle", 0, 64'(bc0), 64'd3);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA; in_ctrl = 12'h0a1;
    cyc();
    in_data = 32'hB; in_ctrl = 12'h0b2;
    cyc();
    chk("skid_full_occ", 0, 64'(occ0), 64'd2);
    chk("skid_full_ready", 0, 64'(ir0), 64'd0);
    chk("skid_full_status", 0, 64'(st0), 64'd3);
    chk("skid_head_a", 0, 64'(od0), 64'hA);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk("skid_head_b", 0, 64'(od0), 64'hB);
    chk("skid_head_b_ctrl", 0, 64'(oc0), 64'h0b2);
    cyc();
    chk("skid_empty", 0, 64'(occ0), 64'd0);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hC;
    cyc();
    in_data = 32'hD;
    cyc();
    in_valid = 1'b0; stall = 1'b1; flush = 1'b1;
    cyc();
    chk("flush_occ", 0, 64'(occ0), 64'd0);
    chk("flush_ctrl", 0, 64'(oc0), 64'd0);
    chk("flush_count", 0, 64'(fc0), 64'd1);
    chk("flush_stall_count", 0, 64'(sc0), 64'd1);
    chk("flush_status", 0, 64'(st0), 64'd2);
    stall = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hE; in_ctrl = 12'h0e7;
    cyc();
    in_valid = 1'b0; stall = 1'b1;
    repeat (5) cyc();
    chk("stall_valid", 0, 64'(ov0), 64'd0);
    chk("stall_hold", 0, 64'(od0), 64'hE);
    chk("stall_count5", 0, 64'(sc0), 64'd6);
    chk("stall_status", 0, 64'(st0), 64'd1);
    stall = 1'b0; out_ready = 1'b1;
    cyc();
    chk("stall_released", 0, 64'(occ0), 64'd0);
    stall = 1'b1;
    repeat (20) cyc();
    chk("stall_saturate", 0, 64'(sc0), 64'd15);
    stall = 1'b0; in_valid = 1'b1;
    repeat (20) begin
      in_data = $urandom;
      in_ctrl = 12'($urandom);
      cyc();
      chk("stream_occ", 1, 64'(occ1), 64'd1);
    end
    out_ready = 1'b0;
    cyc();
    cyc();
    in_valid = 1'b0; reset_n = 1'b0;
    model_reset();
    cyc();
    chk("midreset_valid", 0, 64'(ov0), 64'd0);
    chk("midreset_occ", 0, 64'(occ0), 64'd0);
    reset_n = 1'b1;
    cyc();
    repeat (400) begin
      in_valid = 1'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      stall = $urandom_range(0, 7) == 0;
      flush = $urandom_range(0, 15) == 0;
      in_data = $urandom;
      in_ctrl = 12'($urandom);
      cyc();
    end
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 128, width of the datapath payload (PC+4, operands, immediate, register indices packed by the instantiating stage).
REQ-002 Parameter CTRL_W, default 12, width of the control bundle (regwrite, memtoreg, memwrite, memread, ULAsrc, regdst, ULAcontrol, branch, ...).
REQ-003 Parameter CNT_W, default 32, width of each performance counter.
REQ-004 Parameter SKID, default 1, where 1 selects a 2-entry skid buffer and 0 selects a single register.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  the upstream payload is valid.
REQ-008 in_ready  out  1  the stage accepts the payload this cycle.
REQ-009 in_data  in  DATA_W  upstream payload.
REQ-010 in_ctrl  in  CTRL_W  upstream control bundle.
REQ-011 stall  in  1  hazard-unit freeze: no input accepted and no output delivered.
REQ-012 flush  in  1  synchronous kill of all held entries.
REQ-013 out_valid, out_ready  out, in  1, 1  downstream handshake.
REQ-014 out_data, out_ctrl  out  DATA_W, CTRL_W  head-entry payload and control.
REQ-015 occupancy  out  2  number of held entries (0..2).
REQ-016 stall_count, flush_count, bubble_count  out  CNT_W each  performance counters.
REQ-017 status  out  2  00 NORMAL, 01 STALL, 10 FLUSH, 11 BACKPRESSURE.

Function
REQ-018 An input transfer SHALL occur only when in_valid and in_ready are both 1 on a rising edge; an output transfer SHALL occur only when out_valid and out_ready are both 1.
REQ-019 Entries SHALL leave in FIFO order, with data and control bundles never split or reordered.
REQ-020 Latency SHALL be exactly 1 cycle: a payload accepted at edge N, with the stage previously empty, is on out_data after edge N.
REQ-021 SKID=1: in_ready SHALL be registered, equal to (occupancy<2) and not stall, with no combinational path from out_ready.
REQ-022 SKID=0: in_ready SHALL be (occupancy==0 or out_ready) and not stall, and occupancy SHALL never exceed 1.
REQ-023 When occupancy==2, the head SHALL be in the main register and the newer entry in the skid register; on head transfer, the skid entry moves to main on the same edge.
REQ-024 A simultaneous input and output transfer at occupancy 1 SHALL leave occupancy 1 with the new entry at the head.
REQ-025 out_valid SHALL be (occupancy>0) and not stall and not flush.
REQ-026 out_ctrl SHALL be all-zero whenever out_valid==0, so that bubbles carry no regwrite, memwrite, memread or branch.
REQ-027 flush SHALL take priority over stall: on a flush edge, occupancy goes to 0, both entries clear to zero, and any input presented that cycle is discarded.
REQ-028 While stall==1 and flush==0, all entries SHALL hold unchanged.
REQ-029 stall_count SHALL increment on every edge with stall==1, and flush_count on every edge with flush==1.
REQ-030 bubble_count SHALL increment on every edge with occupancy==0, out_ready==1 and stall==0.
REQ-031 All counters SHALL saturate at all-ones and never wrap.
REQ-032 status SHALL be registered and updated every edge with priority flush>stall>backpressure>normal, where BACKPRESSURE means out_valid==1 and out_ready==0.

Reset
REQ-033 While reset_n==0, asynchronously: out_data, out_ctrl, out_valid, occupancy, all counters and status SHALL be 0, and in_ready SHALL be 0.
REQ-034 On the first edge after reset_n rises with stall==0, in_ready SHALL be 1.
REQ-035 A reset asserted mid-operation SHALL discard all held entries without emitting any output transfer.

Verification
REQ-036 Reset, then in_data=0x...0004 with in_valid=1 and out_ready=1 for one cycle -> out_valid=1 with that data one cycle later, then 0; bubble_count increments on every idle edge.
REQ-037 SKID=1, out_ready=0, push A then B -> occupancy=2, in_ready=0, status=11; then raise out_ready -> A then B on consecutive cycles, occupancy back to 0.
REQ-038 occupancy=2, stall=1 and flush=1 on the same edge -> occupancy=0, out_ctrl=0, flush_count=1, stall_count=1, status=10.
REQ-039 stall held for 5 edges at occupancy=1 -> out_valid=0, entry unchanged, stall_count=5, status=01; after release the entry is delivered intact.
REQ-040 CNT_W=4 with 20 stall edges -> stall_count=15 (saturated).
REQ-041 SKID=0 with streaming in_valid=1 and out_ready=1 -> one transfer per cycle and occupancy never 2.
